// File: rtl/multicycle_controller.sv
// Moore control FSM for the 16-bit multicycle accumulator CPU: fetch, decode, per-instruction sequence.
// Outputs are state-decoded (PCWrite in BRZ follows Zero) and forced to 0 while reset is low.
module multicycle_controller (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] Op,
    input  logic [8:0] Func,
    input  logic       Zero,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic       PCWrite,
    output logic       OldPCWrite,
    output logic       MDRWrite,
    output logic       A3Src,
    output logic       ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic [2:0] ALUControl,
    output logic [1:0] PCSrc,
    output logic       InstrDone,
    output logic       IllegalInstr
);

    localparam logic [3:0] OP_LOAD  = 4'b0000;
    localparam logic [3:0] OP_STORE = 4'b0001;
    localparam logic [3:0] OP_JUMP  = 4'b0010;
    localparam logic [3:0] OP_BRZ   = 4'b0100;
    localparam logic [3:0] OP_TYPEC = 4'b1000;
    localparam logic [3:0] OP_ADDI  = 4'b1100;
    localparam logic [3:0] OP_ANDI  = 4'b1101;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_AND   = 3'b010;
    localparam logic [2:0] ALU_OR    = 3'b011;
    localparam logic [2:0] ALU_NOTB  = 3'b100;
    localparam logic [2:0] ALU_PASSB = 3'b101;
    localparam logic [2:0] ALU_PASSA = 3'b110;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_LDWB   = 4'd4,
        S_MEMWR  = 4'd5,
        S_JUMP   = 4'd6,
        S_BRZ    = 4'd7,
        S_CEXEC  = 4'd8,
        S_CWB    = 4'd9,
        S_IEXEC  = 4'd10,
        S_IWB    = 4'd11
    } state_t;

    state_t state, state_nxt;

    logic func_legal;
    logic func_nop;

    assign func_legal = $onehot(Func) && !Func[8];
    assign func_nop   = (Func == 9'h080);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_FETCH;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt    = S_FETCH;
        AdrSrc       = 1'b0;
        MemWrite     = 1'b0;
        IRWrite      = 1'b0;
        RegWrite     = 1'b0;
        PCWrite      = 1'b0;
        OldPCWrite   = 1'b0;
        MDRWrite     = 1'b0;
        A3Src        = 1'b0;
        ResultSrc    = 1'b0;
        ALUSrcA      = 2'b00;
        ALUSrcB      = 2'b00;
        ImmSrc       = 2'b00;
        ALUControl   = ALU_ADD;
        PCSrc        = 2'b00;
        InstrDone    = 1'b0;
        IllegalInstr = 1'b0;
        // Gating every output here keeps the unreset datapath PC from being written during reset.
        if (reset) begin
            case (state)
                S_FETCH: begin
                    IRWrite    = 1'b1;
                    OldPCWrite = 1'b1;
                    PCWrite    = 1'b1;
                    ALUSrcB    = 2'b01;
                    state_nxt  = S_DECODE;
                end
                S_DECODE: begin
                    case (Op)
                        OP_LOAD, OP_STORE: state_nxt = S_MEMADR;
                        OP_JUMP:           state_nxt = S_JUMP;
                        OP_BRZ:            state_nxt = S_BRZ;
                        OP_ADDI, OP_ANDI:  state_nxt = S_IEXEC;
                        OP_TYPEC: begin
                            if (!func_legal)   IllegalInstr = 1'b1;
                            else if (func_nop) InstrDone    = 1'b1;
                            else               state_nxt    = S_CEXEC;
                        end
                        default: IllegalInstr = 1'b1;
                    endcase
                end
                S_MEMADR: begin
                    ALUSrcB    = 2'b10;
                    ALUControl = ALU_PASSB;
                    state_nxt  = (Op == OP_LOAD) ? S_MEMRD : S_MEMWR;
                end
                S_MEMRD: begin
                    AdrSrc    = 1'b1;
                    MDRWrite  = 1'b1;
                    state_nxt = S_LDWB;
                end
                S_LDWB: begin
                    RegWrite  = 1'b1;
                    ResultSrc = 1'b1;
                    InstrDone = 1'b1;
                end
                S_MEMWR: begin
                    AdrSrc    = 1'b1;
                    MemWrite  = 1'b1;
                    InstrDone = 1'b1;
                end
                S_JUMP: begin
                    PCSrc     = 2'b01;
                    PCWrite   = 1'b1;
                    InstrDone = 1'b1;
                end
                S_BRZ: begin
                    ALUSrcA    = 2'b10;
                    ALUControl = ALU_PASSA;
                    PCSrc      = 2'b10;
                    PCWrite    = Zero;
                    InstrDone  = 1'b1;
                end
                S_CEXEC: begin
                    ALUSrcA = 2'b10;
                    if      (Func[0]) ALUControl = ALU_PASSA;
                    else if (Func[1]) ALUControl = ALU_PASSB;
                    else if (Func[2]) ALUControl = ALU_ADD;
                    else if (Func[3]) ALUControl = ALU_SUB;
                    else if (Func[4]) ALUControl = ALU_AND;
                    else if (Func[5]) ALUControl = ALU_OR;
                    else              ALUControl = ALU_NOTB;
                    state_nxt = S_CWB;
                end
                S_CWB: begin
                    RegWrite  = 1'b1;
                    A3Src     = Func[0];
                    InstrDone = 1'b1;
                end
                S_IEXEC: begin
                    ALUSrcA    = 2'b10;
                    ALUSrcB    = 2'b10;
                    ImmSrc     = 2'b01;
                    ALUControl = (Op == OP_ADDI) ? ALU_ADD : ALU_AND;
                    state_nxt  = S_IWB;
                end
                S_IWB: begin
                    RegWrite  = 1'b1;
                    InstrDone = 1'b1;
                end
                default: state_nxt = S_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: directed and random instructions against a per-instruction cycle table model.
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] Op;
    logic [8:0] Func;
    logic       Zero;
    logic       AdrSrc, MemWrite, IRWrite, RegWrite, PCWrite, OldPCWrite, MDRWrite;
    logic       A3Src, ResultSrc, InstrDone, IllegalInstr;
    logic [1:0] ALUSrcA, ALUSrcB, ImmSrc, PCSrc;
    logic [2:0] ALUControl;

    always #5 clk = ~clk;

    multicycle_controller dut (
        .clk(clk), .reset(reset), .Op(Op), .Func(Func), .Zero(Zero),
        .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
        .PCWrite(PCWrite), .OldPCWrite(OldPCWrite), .MDRWrite(MDRWrite), .A3Src(A3Src),
        .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc),
        .ALUControl(ALUControl), .PCSrc(PCSrc), .InstrDone(InstrDone), .IllegalInstr(IllegalInstr)
    );

    typedef struct packed {
        logic       adr_src, mem_write, ir_write, reg_write, pc_write, old_pc_write, mdr_write;
        logic       a3_src, result_src;
        logic [1:0] alu_src_a, alu_src_b, imm_src;
        logic [2:0] alu_control;
        logic [1:0] pc_src;
        logic       instr_done, illegal_instr;
    } ctrl_t;

    ctrl_t got;
    assign got = {AdrSrc, MemWrite, IRWrite, RegWrite, PCWrite, OldPCWrite, MDRWrite, A3Src,
                  ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl, PCSrc, InstrDone, IllegalInstr};

    int n_cmp = 0;
    int n_err = 0;

    // ALU code for each one-hot func position 0..6.
    localparam logic [2:0] FUNC_ALU [7] = '{3'd6, 3'd5, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4};

    function automatic bit legal_func(input logic [8:0] f);
        return ($countones(f) == 1) && !f[8];
    endfunction

    function automatic int model_len(input logic [3:0] op, input logic [8:0] f);
        case (op)
            4'h0:       return 5;
            4'h1:       return 4;
            4'h2, 4'h4: return 3;
            4'hC, 4'hD: return 4;
            4'h8:       return (legal_func(f) && f != 9'h080) ? 4 : 2;
            default:    return 2;
        endcase
    endfunction

    function automatic ctrl_t model_at(input logic [3:0] op, input logic [8:0] f,
                                       input logic z, input int k);
        ctrl_t c;
        int    idx;
        c = '0;
        idx = 0;
        if (k == 0) begin
            c.ir_write = 1; c.old_pc_write = 1; c.pc_write = 1; c.alu_src_b = 2'b01;
        end else if (k == 1) begin
            if (op inside {4'h0, 4'h1, 4'h2, 4'h4, 4'hC, 4'hD}) c = '0;
            else if (op == 4'h8 && legal_func(f)) c.instr_done = (f == 9'h080);
            else c.illegal_instr = 1;
        end else begin
            case (op)
                4'h0, 4'h1: begin
                    if (k == 2) begin
                        c.alu_src_b = 2'b10; c.alu_control = 3'b101;
                    end else if (op == 4'h1) begin
                        c.adr_src = 1; c.mem_write = 1; c.instr_done = 1;
                    end else if (k == 3) begin
                        c.adr_src = 1; c.mdr_write = 1;
                    end else begin
                        c.reg_write = 1; c.result_src = 1; c.instr_done = 1;
                    end
                end
                4'h2: begin
                    c.pc_src = 2'b01; c.pc_write = 1; c.instr_done = 1;
                end
                4'h4: begin
                    c.alu_src_a = 2'b10; c.alu_control = 3'b110; c.pc_src = 2'b10;
                    c.pc_write = z; c.instr_done = 1;
                end
                4'h8: begin
                    for (int i = 0; i < 7; i++) if (f[i]) idx = i;
                    if (k == 2) begin
                        c.alu_src_a = 2'b10; c.alu_control = FUNC_ALU[idx];
                    end else begin
                        c.reg_write = 1; c.a3_src = f[0]; c.instr_done = 1;
                    end
                end
                default: begin
                    if (k == 2) begin
                        c.alu_src_a = 2'b10; c.alu_src_b = 2'b10; c.imm_src = 2'b01;
                        c.alu_control = (op == 4'hC) ? 3'b000 : 3'b010;
                    end else begin
                        c.reg_write = 1; c.instr_done = 1;
                    end
                end
            endcase
        end
        return c;
    endfunction

    // Entered between a posedge and the next negedge with the DUT in FETCH; returns at posedge+1
    // after the cycle that pulsed InstrDone/IllegalInstr (bounded at 8 cycles).
    task automatic drive_instr(input logic [3:0] op, input logic [8:0] f, input logic z,
                               output ctrl_t obs [8], output int len);
        Op = op; Func = f; Zero = z;
        len = 8;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            obs[c] = got;
            @(posedge clk); #1;
            if (obs[c].instr_done || obs[c].illegal_instr) begin
                len = c + 1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; Op = 4'h0; Func = 9'h004; Zero = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_cmp++;
            if (got !== ctrl_t'('0)) begin
                n_err++; $display("FAIL reset_low cyc%0d: got %h expected %h", c, got, ctrl_t'('0));
            end
        end
        @(posedge clk); #1;
        reset = 1'b1; #1;
        n_cmp++;
        if (got !== model_at(4'h0, 9'h0, 1'b0, 0)) begin
            n_err++; $display("FAIL reset_release_fetch: got %h expected %h", got, model_at(4'h0, 9'h0, 1'b0, 0));
        end
    endtask

    task automatic test_load();
        ctrl_t obs [8];
        int    len;
        drive_instr(4'h0, 9'($urandom), 1'b0, obs, len);
        n_cmp++;
        if (len !== 5) begin n_err++; $display("FAIL load_latency: got %0d expected 5", len); end
        for (int k = 0; k < len && k < 5; k++) begin
            n_cmp++;
            if (obs[k] !== model_at(4'h0, Func, 1'b0, k)) begin
                n_err++; $display("FAIL load cyc%0d: got %h expected %h", k, obs[k], model_at(4'h0, Func, 1'b0, k));
            end
        end
    endtask

    task automatic test_brz();
        ctrl_t obs [8];
        int    len;
        for (int zz = 1; zz >= 0; zz--) begin
            drive_instr(4'h4, 9'($urandom), 1'(zz), obs, len);
            n_cmp++;
            if (len !== 3) begin n_err++; $display("FAIL brz_latency z=%0d: got %0d expected 3", zz, len); end
            for (int k = 0; k < len && k < 3; k++) begin
                n_cmp++;
                if (obs[k] !== model_at(4'h4, Func, 1'(zz), k)) begin
                    n_err++; $display("FAIL brz z=%0d cyc%0d: got %h expected %h", zz, k, obs[k], model_at(4'h4, Func, 1'(zz), k));
                end
            end
        end
    endtask

    task automatic test_typec();
        ctrl_t      obs [8];
        int         len;
        logic [8:0] funcs [4] = '{9'h001, 9'h008, 9'h040, 9'h080};
        for (int t = 0; t < 4; t++) begin
            drive_instr(4'h8, funcs[t], 1'($urandom), obs, len);
            n_cmp++;
            if (len !== model_len(4'h8, funcs[t])) begin
                n_err++; $display("FAIL typec_latency func=%h: got %0d expected %0d", funcs[t], len, model_len(4'h8, funcs[t]));
            end
            for (int k = 0; k < len && k < model_len(4'h8, funcs[t]); k++) begin
                n_cmp++;
                if (obs[k] !== model_at(4'h8, funcs[t], Zero, k)) begin
                    n_err++; $display("FAIL typec func=%h cyc%0d: got %h expected %h", funcs[t], k, obs[k], model_at(4'h8, funcs[t], Zero, k));
                end
            end
        end
    endtask

    task automatic test_illegal();
        ctrl_t      obs [8];
        int         len;
        logic [3:0] ops   [3] = '{4'h8, 4'h8, 4'hF};
        logic [8:0] funcs [3] = '{9'h003, 9'h100, 9'h004};
        for (int t = 0; t < 3; t++) begin
            drive_instr(ops[t], funcs[t], 1'b1, obs, len);
            n_cmp++;
            if (len !== 2 || obs[1].illegal_instr !== 1'b1) begin
                n_err++; $display("FAIL illegal%0d: got len %0d flag %b expected len 2 flag 1", t, len, obs[1].illegal_instr);
            end
            for (int k = 0; k < len && k < 2; k++) begin
                n_cmp++;
                if (obs[k] !== model_at(ops[t], funcs[t], 1'b1, k)) begin
                    n_err++; $display("FAIL illegal%0d cyc%0d: got %h expected %h", t, k, obs[k], model_at(ops[t], funcs[t], 1'b1, k));
                end
            end
        end
    endtask

    task automatic test_reset_mid_store();
        ctrl_t obs [8];
        int    len;
        Op = 4'h1; Func = 9'($urandom); Zero = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_cmp++;
            if (got !== model_at(4'h1, Func, 1'b0, k)) begin
                n_err++; $display("FAIL store cyc%0d: got %h expected %h", k, got, model_at(4'h1, Func, 1'b0, k));
            end
            if (k < 3) begin @(posedge clk); #1; end
        end
        #2 reset = 1'b0;
        #1;
        n_cmp++;
        if (got !== ctrl_t'('0)) begin
            n_err++; $display("FAIL abort_memwrite: got %h expected %h", got, ctrl_t'('0));
        end
        @(posedge clk); #1;
        n_cmp++;
        if (got !== ctrl_t'('0)) begin
            n_err++; $display("FAIL abort_held: got %h expected %h", got, ctrl_t'('0));
        end
        reset = 1'b1;
        drive_instr(4'h2, 9'($urandom), 1'b0, obs, len);
        n_cmp++;
        if (len !== 3) begin n_err++; $display("FAIL restart_latency: got %0d expected 3", len); end
        for (int k = 0; k < len && k < 3; k++) begin
            n_cmp++;
            if (obs[k] !== model_at(4'h2, Func, 1'b0, k)) begin
                n_err++; $display("FAIL restart cyc%0d: got %h expected %h", k, obs[k], model_at(4'h2, Func, 1'b0, k));
            end
        end
    endtask

    task automatic test_random();
        ctrl_t      obs [8];
        int         len;
        int         exp_len;
        logic [3:0] op;
        logic [8:0] f;
        logic [3:0] op_tbl [8] = '{4'h0, 4'h1, 4'h2, 4'h4, 4'h8, 4'h8, 4'hC, 4'hD};
        for (int n = 0; n < 150; n++) begin
            op = ($urandom_range(9, 0) < 8) ? op_tbl[$urandom_range(7, 0)] : 4'($urandom);
            f  = $urandom_range(1, 0) ? (9'h001 << $urandom_range(8, 0)) : 9'($urandom);
            drive_instr(op, f, 1'($urandom), obs, len);
            exp_len = model_len(op, f);
            n_cmp++;
            if (len !== exp_len) begin
                n_err++; $display("FAIL rand%0d op=%h func=%h latency: got %0d expected %0d", n, op, f, len, exp_len);
            end
            for (int k = 0; k < len && k < exp_len; k++) begin
                n_cmp++;
                if (obs[k] !== model_at(op, f, Zero, k)) begin
                    n_err++; $display("FAIL rand%0d op=%h func=%h cyc%0d: got %h expected %h", n, op, f, k, obs[k], model_at(op, f, Zero, k));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_brz();
        test_typec();
        test_illegal();
        test_reset_mid_store();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Main control unit for the 16-bit multicycle accumulator CPU. Sits directly upstream of the datapath and drives every datapath select and write enable.
- Consumes Op, Func and Zero from the datapath.
- Moore FSM: fetch, decode, then an instruction-specific sequence.
- Produces one-cycle InstrDone and IllegalInstr pulses for the bench and top level.

Parameters:
- None. Opcode, func and ALU encodings are fixed, as listed below.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- Op  input  4  Instr[15:12] from datapath.
- Func  input  9  Instr[8:0] from datapath.
- Zero  input  1  combinational ALU zero flag.
- AdrSrc  output  1  0 = PC, 1 = ALUOut memory address.
- MemWrite, IRWrite, RegWrite, PCWrite, OldPCWrite, MDRWrite  output  1 each  write enables.
- A3Src  output  1  0 = R0, 1 = Instr[11:9].
- ResultSrc  output  1  0 = ALUOut, 1 = MDR.
- ALUSrcA  output  2  00 = PC, 01 = OldPC, 10 = A.
- ALUSrcB  output  2  00 = B, 01 = const 1, 10 = ImmExt.
- ImmSrc  output  2  00 = zero-extend Instr[11:0], 01 = sign-extend Instr[11:0].
- ALUControl  output  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 NOT B, 101 PASS B, 110 PASS A.
- PCSrc  output  2  00 = ALUResult, 01 = jump target, 10 = branch target.
- InstrDone  output  1  pulses in the final state of each instruction.
- IllegalInstr  output  1  pulses in DECODE on an undefined op or func.

Behaviour:
- Opcodes: 0000 LOAD, 0001 STORE, 0010 JUMP, 0100 BRZ, 1000 TYPEC, 1100 ADDI, 1101 ANDI. Any other opcode is illegal.
- Func is one-hot:
  - bit0 MOVETO: Ri <- R0.
  - bit1 MOVEFROM: R0 <- Ri.
  - bit2 ADD, bit3 SUB, bit4 AND, bit5 OR: R0 <- R0 op Ri.
  - bit6 NOT: R0 <- ~Ri.
  - bit7 NOP.
  - bit8 set, zero bits set, or more than one bit set is illegal.
- Outputs are decoded from state only, except PCWrite in BRZ, which equals Zero. Every output not listed for a state is 0.
- FETCH: IRWrite = 1, OldPCWrite = 1, PCWrite = 1, ALUSrcB = 01, ALUControl = ADD. -> DECODE.
- DECODE: all outputs 0. Next state:
  - LOAD/STORE -> MEMADR.
  - JUMP -> JUMP.
  - BRZ -> BRZ.
  - ADDI/ANDI -> IEXEC.
  - TYPEC with a legal non-NOP func -> CEXEC.
  - TYPEC NOP -> FETCH with InstrDone = 1.
  - Illegal op/func -> FETCH with IllegalInstr = 1 and no writes.
- MEMADR: ALUSrcB = 10, ImmSrc = 00, ALUControl = PASS B. -> MEMRD for LOAD, MEMWR for STORE.
- MEMRD: AdrSrc = 1, MDRWrite = 1. -> LDWB.
- LDWB: RegWrite = 1, ResultSrc = 1, A3Src = 0, InstrDone = 1. -> FETCH.
- MEMWR: AdrSrc = 1, MemWrite = 1, InstrDone = 1. -> FETCH.
- JUMP: PCSrc = 01, PCWrite = 1, InstrDone = 1. -> FETCH.
- BRZ: ALUSrcA = 10, ALUControl = PASS A, PCSrc = 10, PCWrite = Zero, InstrDone = 1. -> FETCH.
- CEXEC: ALUSrcA = 10, ALUSrcB = 00. ALUControl by func:
  - MOVETO = PASS A, MOVEFROM = PASS B, NOT = NOT B.
  - ADD/SUB/AND/OR use the matching code.
  - -> CWB.
- CWB: RegWrite = 1, ResultSrc = 0, A3Src = 1 iff MOVETO, InstrDone = 1. -> FETCH.
  - Func is re-read in CWB; the IR is stable because IRWrite is 0 outside FETCH.
- IEXEC: ALUSrcA = 10, ALUSrcB = 10, ImmSrc = 01, ALUControl = ADD for ADDI, AND for ANDI. -> IWB.
- IWB: RegWrite = 1, ResultSrc = 0, A3Src = 0, InstrDone = 1. -> FETCH.
- Instruction latencies, counted in cycles including FETCH:
  - LOAD 5, STORE 4, JUMP 3, BRZ 3.
  - TYPEC 4, ADDI/ANDI 4, NOP 2, illegal 2.
- Reset:
  - While reset = 0: state is forced to FETCH, and every output is forced to 0, including FETCH's enables. The datapath PC has no reset of its own, so no write can occur during reset.
  - The first rising edge after release executes FETCH.
  - Asserting reset mid-instruction aborts it immediately. No partial write completes once outputs are gated.
- State encoding is free. Unreachable states recover to FETCH on the next edge with all outputs 0.

Test Plan:
- Reset held low for 3 cycles, then released: all outputs 0 while low. First cycle after release shows IRWrite = 1, PCWrite = 1, ALUSrcB = 01, ALUControl = 000.
- Op = 0000 (LOAD): state sequence FETCH, DECODE, MEMADR, MEMRD, LDWB. MEMRD shows AdrSrc = 1, MDRWrite = 1. LDWB shows RegWrite = 1, ResultSrc = 1, InstrDone = 1 on cycle 5.
- Op = 0100 (BRZ) with Zero = 1: third cycle shows PCWrite = 1, PCSrc = 10. Repeat with Zero = 0: PCWrite = 0 and InstrDone still 1.
- Op = 1000 with Func = 9'h001 (MOVETO): CEXEC ALUControl = 110, CWB A3Src = 1. Repeat with Func = 9'h008 (SUB): ALUControl = 001, A3Src = 0.
- Op = 1000 with Func = 9'h003, Func = 9'h100, and Op = 1111: each returns to FETCH after DECODE with IllegalInstr = 1 for one cycle and no write enable ever asserted.
- Reset asserted during MEMWR of a STORE: MemWrite drops to 0 immediately. After release, execution restarts at FETCH.
